// File: rtl/vote_tally_engine.sv
// rtl/vote_tally_engine.sv - debounced N-candidate vote tally with lockout, saturation and winner/tie scan
module vote_tally_engine #(
    parameter int NUM_CAND   = 4,
    parameter int CNT_W      = 8,
    parameter int DEBOUNCE   = 10,
    parameter int ACK_CYCLES = 10,
    localparam int IDX_W     = (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic [IDX_W-1:0]    sel,
    output logic [CNT_W-1:0]    led,
    output logic                vote_ack,
    output logic                reject,
    output logic [IDX_W-1:0]    winner,
    output logic                winner_valid,
    output logic                tie,
    output logic                overflow
);

    localparam int DB_W = $clog2(DEBOUNCE + 2);
    localparam int LK_W = $clog2(ACK_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [DB_W-1:0]     DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0]     DB_SAT   = DB_W'(DEBOUNCE + 1);
    localparam logic [DB_W-1:0]     DB_EDGE  = DB_W'(DEBOUNCE - 1);
    localparam logic [LK_W-1:0]     LK_LOAD  = LK_W'(ACK_CYCLES);
    localparam logic [LK_W-1:0]     LK_ONE   = LK_W'(1);
    localparam logic [NUM_CAND-1:0] P_ONE    = NUM_CAND'(1);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    scan_state_e            state_q, state_d;
    logic [DB_W-1:0]        db_q [NUM_CAND];
    logic [DB_W-1:0]        db_d [NUM_CAND];
    logic [NUM_CAND-1:0]    press_q, press_d;
    logic [CNT_W-1:0]       tally_q [NUM_CAND];
    logic [CNT_W-1:0]       tally_d [NUM_CAND];
    logic [LK_W-1:0]        lock_q, lock_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       led_q, led_d;
    logic                   mode_q, mode_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       max_q, max_d;
    logic [IDX_W-1:0]       arg_q, arg_d;
    logic                   tacc_q, tacc_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic                   wv_q, wv_d;
    logic                   tie_q, tie_d;

    logic [NUM_CAND-1:0]    grant;
    logic                   press_any;
    logic                   press_multi;
    logic                   lock_busy;
    logic                   accept;
    logic                   drop;
    logic [CNT_W-1:0]       scan_val;

    // Lowest-index press wins; any other press in the same cycle is a drop.
    assign grant       = press_q & (~press_q + P_ONE);
    assign press_any   = |press_q;
    assign press_multi = |(press_q & ~grant);
    assign lock_busy   = (lock_q != '0);
    assign accept      = !mode && press_any && !lock_busy;
    assign drop        = !mode && press_any && (lock_busy || press_multi);

    always_comb begin
        scan_val = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (idx_q == IDX_W'(i)) scan_val = tally_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CAND; i++) begin
            db_d[i]    = db_q[i];
            tally_d[i] = tally_q[i];
        end
        press_d  = '0;
        lock_d   = lock_q;
        ovf_d    = ovf_q;
        led_d    = '0;
        mode_d   = mode;
        state_d  = state_q;
        idx_d    = idx_q;
        max_d    = max_q;
        arg_d    = arg_q;
        tacc_d   = tacc_q;
        winner_d = winner_q;
        wv_d     = wv_q;
        tie_d    = tie_q;

        // Counter saturates above the press threshold so a held button fires once.
        for (int i = 0; i < NUM_CAND; i++) begin
            if (button[i]) begin
                if (db_q[i] != DB_SAT) db_d[i] = db_q[i] + DB_ONE;
                press_d[i] = (db_q[i] == DB_EDGE);
            end else begin
                db_d[i] = '0;
            end
        end

        if (accept) begin
            lock_d = LK_LOAD;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (grant[i]) begin
                    if (tally_q[i] == CNT_MAX) ovf_d = 1'b1;
                    else                       tally_d[i] = tally_q[i] + CNT_ONE;
                end
            end
        end else if (lock_busy) begin
            lock_d = lock_q - LK_ONE;
        end

        if (mode) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (sel == IDX_W'(i)) led_d = tally_q[i];
            end
        end else if (lock_busy) begin
            led_d = '1;
        end

        case (state_q)
            S_IDLE: begin
                if (mode && !mode_q) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (idx_q == '0) begin
                    max_d  = scan_val;
                    arg_d  = '0;
                    tacc_d = 1'b0;
                end else if (scan_val > max_q) begin
                    max_d  = scan_val;
                    arg_d  = idx_q;
                    tacc_d = 1'b0;
                end else if (scan_val == max_q) begin
                    tacc_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d  = S_DONE;
                    winner_d = arg_d;
                    tie_d    = tacc_d;
                    wv_d     = !tacc_d;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Leaving result mode abandons any scan and clears the verdict.
        if (!mode) begin
            state_d  = S_IDLE;
            winner_d = '0;
            wv_d     = 1'b0;
            tie_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                db_q[i]    <= '0;
                tally_q[i] <= '0;
            end
            press_q  <= '0;
            lock_q   <= '0;
            ovf_q    <= 1'b0;
            led_q    <= '0;
            mode_q   <= 1'b0;
            state_q  <= S_IDLE;
            idx_q    <= '0;
            max_q    <= '0;
            arg_q    <= '0;
            tacc_q   <= 1'b0;
            winner_q <= '0;
            wv_q     <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                db_q[i]    <= db_d[i];
                tally_q[i] <= tally_d[i];
            end
            press_q  <= press_d;
            lock_q   <= lock_d;
            ovf_q    <= ovf_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            arg_q    <= arg_d;
            tacc_q   <= tacc_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
            tie_q    <= tie_d;
        end
    end

    assign led          = led_q;
    assign vote_ack     = lock_busy;
    assign reject       = drop;
    assign winner       = winner_q;
    assign winner_valid = wv_q;
    assign tie          = tie_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_vote_tally_engine.sv
// tb/tb_vote_tally_engine.sv - directed and random stimulus against an integer reference model
module tb_vote_tally_engine;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int DB   = 10;
    localparam int ACK  = 10;
    localparam int IW   = 2;
    localparam int TMAX = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [N-1:0]  button;
    logic [IW-1:0] sel;
    logic [W-1:0]  led;
    logic          vote_ack;
    logic          reject;
    logic [IW-1:0] winner;
    logic          winner_valid;
    logic          tie;
    logic          overflow;

    vote_tally_engine #(
        .NUM_CAND(N), .CNT_W(W), .DEBOUNCE(DB), .ACK_CYCLES(ACK)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .button(button), .sel(sel),
        .led(led), .vote_ack(vote_ack), .reject(reject), .winner(winner),
        .winner_valid(winner_valid), .tie(tie), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rej_seen = 0;

    // Reference state: run lengths, pending presses, plain integer tallies.
    int m_run [N];
    bit m_pend [N];
    int m_tally [N];
    int m_lock, m_led, m_es, m_win;
    bit m_ovf, m_prev_mode, m_started, m_wv, m_tie;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_pend[i] = 0; m_tally[i] = 0;
        end
        m_lock = 0; m_led = 0; m_es = 0; m_win = 0;
        m_ovf = 0; m_prev_mode = 0; m_started = 0; m_wv = 0; m_tie = 0;
    endtask

    task automatic model_edge();
        int npend, first, mx, nmx;
        if (reset) begin
            model_clear();
            return;
        end
        m_led = mode ? ((int'(sel) < N) ? m_tally[sel] : 0) : ((m_lock > 0) ? TMAX : 0);
        npend = 0; first = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin
                npend++;
                if (first < 0) first = i;
            end
        end
        if (!mode && npend > 0 && m_lock == 0) begin
            if (m_tally[first] == TMAX) m_ovf = 1;
            else m_tally[first] = m_tally[first] + 1;
            m_lock = ACK;
        end else if (m_lock > 0) begin
            m_lock = m_lock - 1;
        end
        for (int i = 0; i < N; i++) begin
            m_run[i] = button[i] ? m_run[i] + 1 : 0;
            m_pend[i] = (m_run[i] == DB);
        end
        if (!mode) begin
            m_started = 0; m_wv = 0; m_tie = 0; m_win = 0;
        end else if (!m_prev_mode) begin
            m_started = 1; m_es = 1;
        end else if (m_started) begin
            m_es++;
            if (m_es == N + 1) begin
                mx = -1; nmx = 0;
                for (int i = 0; i < N; i++) begin
                    if (m_tally[i] > mx) begin mx = m_tally[i]; nmx = 1; m_win = i; end
                    else if (m_tally[i] == mx) nmx++;
                end
                m_wv = (nmx == 1);
                m_tie = (nmx > 1);
            end
        end
        m_prev_mode = mode;
    endtask

    task automatic check_outputs();
        chk("led", led, m_led);
        chk("vote_ack", vote_ack, m_lock > 0);
        chk("winner", winner, m_win);
        chk("winner_valid", winner_valid, m_wv);
        chk("tie", tie, m_tie);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step();
        int npend;
        bit exp_rej;
        #1;
        npend = 0;
        for (int i = 0; i < N; i++) npend += int'(m_pend[i]);
        exp_rej = !mode && npend > 0 && (m_lock > 0 || npend > 1);
        chk("reject", reject, exp_rej);
        if (reject === 1'b1) rej_seen++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic vote(int idx);
        button = N'(1) << idx;
        repeat (12) step();
        button = '0;
        repeat (10) step();
    endtask

    task automatic show(int idx);
        mode = 1'b1;
        sel = IW'(idx);
        repeat (2) step();
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; button = '0; sel = '0;
        model_clear();
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_outputs();
        chk("reset_reject", reject, 0);
        step();
        reset = 1'b0;

        // Held button counts once; release and repress counts again.
        button = 4'b0100;
        repeat (20) step();
        button = '0;
        repeat (3) step();
        button = 4'b0100;
        repeat (20) step();
        button = '0;
        repeat (3) step();
        show(2);
        chk("tally2_twice", led, 2);
        mode = 1'b0;
        step();

        // Too-short press registers nothing.
        rej_seen = 0;
        button = 4'b0001;
        repeat (9) step();
        button = '0;
        repeat (5) step();
        chk("short_press_rej", rej_seen, 0);
        show(0);
        chk("short_press_tally", led, 0);
        mode = 1'b0;
        step();

        // Simultaneous presses, then a press landing inside the lockout.
        rej_seen = 0;
        button = 4'b1010;
        repeat (3) step();
        button = 4'b1011;
        repeat (9) step();
        button = 4'b0001;
        repeat (3) step();
        button = '0;
        repeat (12) step();
        chk("drop_rej_count", rej_seen, 2);
        show(1);
        chk("tally1_arb", led, 1);
        show(3);
        chk("tally3_arb", led, 0);
        show(0);
        chk("tally0_locked", led, 0);
        mode = 1'b0;
        step();

        // Tie then unique winner.
        reset = 1'b1; step(); reset = 1'b0;
        repeat (3) vote(0);
        repeat (5) vote(1);
        repeat (5) vote(2);
        vote(3);
        mode = 1'b1;
        repeat (5) step();
        chk("tie_flag", tie, 1);
        chk("tie_wv", winner_valid, 0);
        mode = 1'b0;
        step();
        vote(2);
        mode = 1'b1; sel = 2'd2;
        repeat (5) step();
        chk("win_idx", winner, 2);
        chk("win_valid", winner_valid, 1);
        chk("win_led", led, 6);
        mode = 1'b0;
        step();

        // Reset mid-lockout with button held, then mid-scan.
        button = 4'b0010;
        repeat (13) step();
        reset = 1'b1;
        step();
        chk("rst_ack", vote_ack, 0);
        chk("rst_led", led, 0);
        reset = 1'b0;
        repeat (11) step();
        chk("rearm_ack", vote_ack, 1);
        button = '0;
        repeat (12) step();
        mode = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("rst_scan_wv", winner_valid, 0);
        chk("rst_scan_tie", tie, 0);
        reset = 1'b0;
        repeat (6) step();
        chk("post_rst_scan_tie", tie, 1);
        mode = 1'b0;
        step();

        // Saturation and sticky overflow.
        reset = 1'b1; step(); reset = 1'b0;
        repeat (255) vote(0);
        chk("ovf_at_255", overflow, 0);
        vote(0);
        chk("ovf_at_256", overflow, 1);
        repeat (4) vote(0);
        chk("ovf_sticky", overflow, 1);
        show(0);
        chk("tally0_sat", led, TMAX);
        mode = 1'b0;
        step();

        // Random mixing of buttons, mode, sel and occasional reset.
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(15) == 0) button[i] = ~button[i];
            if ($urandom_range(49) == 0) mode = ~mode;
            if ($urandom_range(7) == 0) sel = IW'($urandom_range(N - 1));
            reset = ($urandom_range(399) == 0);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
